// File: rtl/layers_mosi_dispatcher_pkg.sv
// Shared definitions for the layer MOSI dispatcher: FSM states and header constants.
package layers_pkg;

    typedef enum logic [2:0] {
        HDR_ID,
        HDR_LEN_H,
        HDR_LEN_L,
        PAYLOAD,
        DROP
    } layers_state_e;

    localparam logic [7:0]  LAYERS_BROADCAST_ID = 8'hFF;
    localparam int unsigned LAYERS_LEN_W        = 16;

endpackage

// File: rtl/layers_mosi_dispatcher_if.sv
// Host command stream plus per-layer MOSI streams; slave is the dispatcher view.
interface layers_mosi_dispatcher_if #(
    parameter int unsigned LAYER_COUNT = 5
);
    logic [7:0]               cmd_s_axis_tdata;
    logic                     cmd_s_axis_tvalid;
    logic                     cmd_s_axis_tready;
    logic [LAYER_COUNT*8-1:0] layers_mosi_m_axis_tdata;
    logic [LAYER_COUNT-1:0]   layers_mosi_m_axis_tvalid;
    logic [LAYER_COUNT-1:0]   layers_mosi_m_axis_tlast;
    logic [LAYER_COUNT-1:0]   layers_mosi_m_axis_tready;

    modport slave (
        input  cmd_s_axis_tdata, cmd_s_axis_tvalid, layers_mosi_m_axis_tready,
        output cmd_s_axis_tready, layers_mosi_m_axis_tdata,
               layers_mosi_m_axis_tvalid, layers_mosi_m_axis_tlast
    );

    modport master (
        output cmd_s_axis_tdata, cmd_s_axis_tvalid, layers_mosi_m_axis_tready,
        input  cmd_s_axis_tready, layers_mosi_m_axis_tdata,
               layers_mosi_m_axis_tvalid, layers_mosi_m_axis_tlast
    );

endinterface

// File: rtl/layers_mosi_bcast_slice.sv
// One-byte output register shared by all lanes; each lane keeps its own pending bit.
module layers_mosi_bcast_slice #(
    parameter int unsigned LAYER_COUNT = 5
) (
    input  logic                   clk_core,
    input  logic                   clk_core_resn,
    input  logic                   load,
    input  logic [7:0]             load_data,
    input  logic                   load_last,
    input  logic [LAYER_COUNT-1:0] load_mask,
    input  logic [LAYER_COUNT-1:0] lane_ready,
    output logic [LAYER_COUNT-1:0] pending,
    output logic [7:0]             data,
    output logic                   last,
    output logic                   can_load
);

    logic [LAYER_COUNT-1:0] pending_q;
    logic [7:0]             data_q;
    logic                   tlast_q;

    // Loading is allowed in the same cycle the final outstanding lane handshakes.
    assign can_load = ((pending_q & ~lane_ready) == '0);

    always_ff @(posedge clk_core) begin
        if (!clk_core_resn) begin
            pending_q <= '0;
            data_q    <= '0;
            tlast_q   <= 1'b0;
        end else if (load) begin
            pending_q <= load_mask;
            data_q    <= load_data;
            tlast_q   <= load_last;
        end else begin
            pending_q <= pending_q & ~lane_ready;
        end
    end

    assign pending = pending_q;
    assign data    = data_q;
    assign last    = tlast_q;

endmodule

// File: rtl/layers_mosi_dispatcher.sv
// Parses ID/LEN-framed host commands and fans payload bytes out to one or all layers.
import layers_pkg::*;

module layers_mosi_dispatcher #(
    parameter int unsigned LAYER_COUNT = 5
) (
    input  logic                      clk_core,
    input  logic                      clk_core_resn,
    layers_mosi_dispatcher_if.slave   bus,
    output logic                      status_busy,
    output logic [15:0]               stat_drop_count
);

    layers_state_e             state_q, state_d;
    logic [LAYER_COUNT-1:0]    mask_q, id_mask, pending;
    logic [7:0]                len_h_q, slice_data;
    logic [LAYERS_LEN_W-1:0]   remaining_q, hdr_len;
    logic [15:0]               drop_count_q;
    logic                      cmd_ready, accept, slice_load, slice_ready, slice_last, last_byte;

    always_comb begin
        id_mask = '0;
        for (int unsigned i = 0; i < LAYER_COUNT; i++) begin
            id_mask[i] = (bus.cmd_s_axis_tdata == i[7:0]);
        end
        if (bus.cmd_s_axis_tdata == LAYERS_BROADCAST_ID) begin
            id_mask = '1;
        end
    end

    assign hdr_len   = {len_h_q, bus.cmd_s_axis_tdata};
    assign last_byte = (remaining_q == 16'd1);
    assign accept    = cmd_ready && bus.cmd_s_axis_tvalid;

    always_ff @(posedge clk_core) begin
        if (!clk_core_resn) begin
            state_q <= HDR_ID;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        slice_load = 1'b0;
        unique case (state_q)
            HDR_ID: begin
                cmd_ready = 1'b1;
                if (bus.cmd_s_axis_tvalid) state_d = HDR_LEN_H;
            end
            HDR_LEN_H: begin
                cmd_ready = 1'b1;
                if (bus.cmd_s_axis_tvalid) state_d = HDR_LEN_L;
            end
            HDR_LEN_L: begin
                cmd_ready = 1'b1;
                if (bus.cmd_s_axis_tvalid) begin
                    if (hdr_len == '0)       state_d = HDR_ID;
                    else if (mask_q == '0)   state_d = DROP;
                    else                     state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                cmd_ready = slice_ready;
                if (bus.cmd_s_axis_tvalid && slice_ready) begin
                    slice_load = 1'b1;
                    if (last_byte) state_d = HDR_ID;
                end
            end
            DROP: begin
                cmd_ready = 1'b1;
                if (bus.cmd_s_axis_tvalid && last_byte) state_d = HDR_ID;
            end
            default: state_d = HDR_ID;
        endcase
        // Hold off the host for the whole reset cycle so nothing is taken as byte0 early.
        if (!clk_core_resn) begin
            cmd_ready  = 1'b0;
            slice_load = 1'b0;
        end
    end

    always_ff @(posedge clk_core) begin
        if (!clk_core_resn) begin
            mask_q       <= '0;
            len_h_q      <= '0;
            remaining_q  <= '0;
            drop_count_q <= '0;
        end else if (accept) begin
            case (state_q)
                HDR_ID:    mask_q  <= id_mask;
                HDR_LEN_H: len_h_q <= bus.cmd_s_axis_tdata;
                HDR_LEN_L: begin
                    remaining_q <= hdr_len;
                    if (hdr_len != '0 && mask_q == '0 && drop_count_q != 16'hFFFF) begin
                        drop_count_q <= drop_count_q + 16'd1;
                    end
                end
                PAYLOAD, DROP: remaining_q <= remaining_q - 16'd1;
                default: ;
            endcase
        end
    end

    layers_mosi_bcast_slice #(
        .LAYER_COUNT (LAYER_COUNT)
    ) u_slice (
        .clk_core      (clk_core),
        .clk_core_resn (clk_core_resn),
        .load          (slice_load),
        .load_data     (bus.cmd_s_axis_tdata),
        .load_last     (last_byte),
        .load_mask     (mask_q),
        .lane_ready    (bus.layers_mosi_m_axis_tready),
        .pending       (pending),
        .data          (slice_data),
        .last          (slice_last),
        .can_load      (slice_ready)
    );

    assign bus.cmd_s_axis_tready         = cmd_ready;
    assign bus.layers_mosi_m_axis_tvalid = pending;
    assign bus.layers_mosi_m_axis_tdata  = {LAYER_COUNT{slice_data}};
    assign bus.layers_mosi_m_axis_tlast  = {LAYER_COUNT{slice_last}};
    assign status_busy                   = (state_q != HDR_ID) || (pending != '0);
    assign stat_drop_count               = drop_count_q;

endmodule

// File: tb/tb_layers_mosi_dispatcher.sv
// Directed bench for layers_mosi_dispatcher with LAYER_COUNT=5.
module tb_layers_mosi_dispatcher;

    localparam int unsigned LC = 5;

    logic        clk = 1'b0;
    logic        resn = 1'b0;
    logic        busy;
    logic [15:0] drops;
    int          n_assert = 0;
    int          n_fail = 0;
    int          hs_cnt [LC];
    int          hs_base [LC];

    layers_mosi_dispatcher_if #(.LAYER_COUNT(LC)) bus ();

    layers_mosi_dispatcher #(.LAYER_COUNT(LC)) dut (
        .clk_core        (clk),
        .clk_core_resn   (resn),
        .bus             (bus),
        .status_busy     (busy),
        .stat_drop_count (drops)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < LC; i++) hs_cnt[i] = 0;

    always @(posedge clk) begin
        for (int i = 0; i < LC; i++) begin
            if (bus.layers_mosi_m_axis_tvalid[i] && bus.layers_mosi_m_axis_tready[i])
                hs_cnt[i] <= hs_cnt[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the command inputs, then settle so checks sample mid-cycle.
    task automatic drv(input logic v, input logic [7:0] d);
        bus.cmd_s_axis_tvalid = v;
        bus.cmd_s_axis_tdata  = d;
        #1;
    endtask

    function automatic logic [7:0] lane(input int i);
        logic [LC*8-1:0] all;
        all = bus.layers_mosi_m_axis_tdata;
        return all[8*i +: 8];
    endfunction

    task automatic snap();
        for (int i = 0; i < LC; i++) hs_base[i] = hs_cnt[i];
    endtask

    initial begin
        bus.cmd_s_axis_tvalid         = 1'b0;
        bus.cmd_s_axis_tdata          = 8'h00;
        bus.layers_mosi_m_axis_tready = '1;

        // Reset state
        tick();
        #1;
        chk("rst_cmd_ready", 32'(bus.cmd_s_axis_tready), 32'h0);
        tick();
        chk("rst_tvalid", 32'(bus.layers_mosi_m_axis_tvalid), 32'h0);
        chk("rst_drops", 32'(drops), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        resn = 1'b1;
        drv(1'b0, 8'h00);
        chk("idle_cmd_ready", 32'(bus.cmd_s_axis_tready), 32'h1);
        tick();

        // Single layer: 02 00 03 AA BB CC
        snap();
        drv(1'b1, 8'h02); tick();
        drv(1'b1, 8'h00); tick();
        drv(1'b1, 8'h03); tick();
        drv(1'b1, 8'hAA);
        chk("s_ready_first", 32'(bus.cmd_s_axis_tready), 32'h1);
        tick();
        drv(1'b1, 8'hBB);
        chk("s_valid_aa", 32'(bus.layers_mosi_m_axis_tvalid), 32'h04);
        chk("s_data_aa", 32'(lane(2)), 32'hAA);
        chk("s_last_aa", 32'(bus.layers_mosi_m_axis_tlast), 32'h00);
        chk("s_ready_stream", 32'(bus.cmd_s_axis_tready), 32'h1);
        tick();
        drv(1'b1, 8'hCC);
        chk("s_valid_bb", 32'(bus.layers_mosi_m_axis_tvalid), 32'h04);
        chk("s_data_bb", 32'(lane(2)), 32'hBB);
        chk("s_last_bb", 32'(bus.layers_mosi_m_axis_tlast), 32'h00);
        tick();
        drv(1'b0, 8'h00);
        chk("s_valid_cc", 32'(bus.layers_mosi_m_axis_tvalid), 32'h04);
        chk("s_data_cc", 32'(lane(2)), 32'hCC);
        chk("s_last_cc", 32'(bus.layers_mosi_m_axis_tlast), 32'h1F);
        chk("s_busy_tail", 32'(busy), 32'h1);
        tick();
        chk("s_valid_done", 32'(bus.layers_mosi_m_axis_tvalid), 32'h0);
        chk("s_busy_done", 32'(busy), 32'h0);
        chk("s_hs_lane2", 32'(hs_cnt[2] - hs_base[2]), 32'd3);
        chk("s_hs_lane0", 32'(hs_cnt[0] - hs_base[0]), 32'd0);

        // Broadcast with layer 0 stalled for 3 cycles: FF 00 02 11 22
        snap();
        bus.layers_mosi_m_axis_tready = 5'b11110;
        drv(1'b1, 8'hFF); tick();
        drv(1'b1, 8'h00); tick();
        drv(1'b1, 8'h02); tick();
        drv(1'b1, 8'h11); tick();
        drv(1'b1, 8'h22);
        chk("b_valid_all", 32'(bus.layers_mosi_m_axis_tvalid), 32'h1F);
        chk("b_data_11", 32'(lane(4)), 32'h11);
        chk("b_ready_stall1", 32'(bus.cmd_s_axis_tready), 32'h0);
        tick();
        chk("b_valid_lane0", 32'(bus.layers_mosi_m_axis_tvalid), 32'h01);
        chk("b_data_hold", 32'(lane(0)), 32'h11);
        chk("b_ready_stall2", 32'(bus.cmd_s_axis_tready), 32'h0);
        tick();
        chk("b_valid_lane0b", 32'(bus.layers_mosi_m_axis_tvalid), 32'h01);
        chk("b_ready_stall3", 32'(bus.cmd_s_axis_tready), 32'h0);
        bus.layers_mosi_m_axis_tready = '1;
        #1;
        chk("b_ready_release", 32'(bus.cmd_s_axis_tready), 32'h1);
        tick();
        drv(1'b0, 8'h00);
        chk("b_valid_22", 32'(bus.layers_mosi_m_axis_tvalid), 32'h1F);
        chk("b_data_22", 32'(lane(0)), 32'h22);
        chk("b_last_22", 32'(bus.layers_mosi_m_axis_tlast), 32'h1F);
        tick();
        chk("b_valid_done", 32'(bus.layers_mosi_m_axis_tvalid), 32'h0);
        for (int i = 0; i < LC; i++)
            chk($sformatf("b_hs_lane%0d", i), 32'(hs_cnt[i] - hs_base[i]), 32'd2);

        // Invalid ID: 09 00 04 + 4 bytes, then 04 00 01 C3
        begin
            logic [7:0] bad [7];
            bad = '{8'h09, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
            for (int k = 0; k < 7; k++) begin
                drv(1'b1, bad[k]);
                chk($sformatf("d_ready_%0d", k), 32'(bus.cmd_s_axis_tready), 32'h1);
                tick();
                chk($sformatf("d_valid_%0d", k), 32'(bus.layers_mosi_m_axis_tvalid), 32'h0);
            end
        end
        chk("d_drops", 32'(drops), 32'd1);
        chk("d_busy", 32'(busy), 32'h0);
        drv(1'b1, 8'h04); tick();
        drv(1'b1, 8'h00); tick();
        drv(1'b1, 8'h01); tick();
        drv(1'b1, 8'hC3); tick();
        drv(1'b0, 8'h00);
        chk("d_next_valid", 32'(bus.layers_mosi_m_axis_tvalid), 32'h10);
        chk("d_next_data", 32'(lane(4)), 32'hC3);
        chk("d_next_last", 32'(bus.layers_mosi_m_axis_tlast), 32'h1F);
        tick();

        // Zero length: 01 00 00 then 01 00 01 5A
        drv(1'b1, 8'h01); tick();
        drv(1'b1, 8'h00); tick();
        drv(1'b1, 8'h00); tick();
        drv(1'b0, 8'h00);
        chk("z_valid_none", 32'(bus.layers_mosi_m_axis_tvalid), 32'h0);
        chk("z_busy_idle", 32'(busy), 32'h0);
        chk("z_drops_same", 32'(drops), 32'd1);
        drv(1'b1, 8'h01); tick();
        drv(1'b1, 8'h00); tick();
        drv(1'b1, 8'h01); tick();
        chk("z_valid_pre", 32'(bus.layers_mosi_m_axis_tvalid), 32'h0);
        drv(1'b1, 8'h5A); tick();
        drv(1'b0, 8'h00);
        chk("z_valid_5a", 32'(bus.layers_mosi_m_axis_tvalid), 32'h02);
        chk("z_data_5a", 32'(lane(1)), 32'h5A);
        chk("z_last_5a", 32'(bus.layers_mosi_m_axis_tlast), 32'h1F);
        tick();

        // Reset after 2 of 10 payload bytes of 00 00 0A
        drv(1'b1, 8'h00); tick();
        drv(1'b1, 8'h00); tick();
        drv(1'b1, 8'h0A); tick();
        drv(1'b1, 8'hD0); tick();
        drv(1'b1, 8'hD1); tick();
        bus.layers_mosi_m_axis_tready = '0;
        resn = 1'b0;
        drv(1'b0, 8'h00);
        chk("r_valid_before", 32'(bus.layers_mosi_m_axis_tvalid), 32'h01);
        chk("r_data_before", 32'(lane(0)), 32'hD1);
        chk("r_ready_in_rst", 32'(bus.cmd_s_axis_tready), 32'h0);
        tick();
        chk("r_valid_after", 32'(bus.layers_mosi_m_axis_tvalid), 32'h0);
        chk("r_last_after", 32'(bus.layers_mosi_m_axis_tlast), 32'h0);
        chk("r_busy_after", 32'(busy), 32'h0);
        chk("r_drops_after", 32'(drops), 32'h0);
        resn = 1'b1;
        bus.layers_mosi_m_axis_tready = '1;
        drv(1'b1, 8'h03); tick();
        drv(1'b1, 8'h00); tick();
        drv(1'b1, 8'h01); tick();
        drv(1'b1, 8'h77); tick();
        drv(1'b0, 8'h00);
        chk("r_valid_77", 32'(bus.layers_mosi_m_axis_tvalid), 32'h08);
        chk("r_data_77", 32'(lane(3)), 32'h77);
        chk("r_last_77", 32'(bus.layers_mosi_m_axis_tlast), 32'h1F);
        tick();

        // Drop counter saturation: 65537 invalid commands 09 00 01 xx
        for (int n = 1; n <= 65537; n++) begin
            drv(1'b1, 8'h09); tick();
            drv(1'b1, 8'h00); tick();
            drv(1'b1, 8'h01); tick();
            drv(1'b1, 8'hEE); tick();
            if (n == 1000)  chk("sat_1000", 32'(drops), 32'd1000);
            if (n == 65535) chk("sat_reach", 32'(drops), 32'hFFFF);
        end
        drv(1'b0, 8'h00);
        chk("sat_hold", 32'(drops), 32'hFFFF);
        chk("sat_valid", 32'(bus.layers_mosi_m_axis_tvalid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/layers_mosi_dispatcher.md
LAYERS_MOSI_DISPATCHER -- requirements
Module: layers_mosi_dispatcher

Interface
REQ-001 The block SHALL have parameter LAYER_COUNT, default 5, giving the number of layer MOSI streams (1..254).
REQ-002 The block SHALL have port clk_core, input, 1 bit: the single clock. The design SHALL use one clock, with a synchronous, active-low reset.
REQ-003 The block SHALL have port clk_core_resn, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have the host command stream ports:
- cmd_s_axis_tdata, input, 8 bits.
- cmd_s_axis_tvalid, input, 1 bit.
- cmd_s_axis_tready, output, 1 bit.
REQ-005 The block SHALL have the per-layer output stream ports:
- layers_mosi_m_axis_tdata, output, LAYER_COUNT*8 bits; the same byte is replicated in every lane.
- layers_mosi_m_axis_tvalid, output, LAYER_COUNT bits.
- layers_mosi_m_axis_tlast, output, LAYER_COUNT bits.
- layers_mosi_m_axis_tready, input, LAYER_COUNT bits.
REQ-006 The block SHALL have status_busy, output, 1 bit: high whenever the state is not HDR_ID or a byte is pending.
REQ-007 The block SHALL have stat_drop_count, output, 16 bits: a saturating count of dropped commands.

Function
REQ-008 The command format SHALL be:
- byte0 = target ID: 0..LAYER_COUNT-1 selects one layer; 0xFF is broadcast to all layers; any other value is invalid.
- byte1 = LEN[15:8], byte2 = LEN[7:0].
- LEN payload bytes follow.
REQ-009 The FSM SHALL have states HDR_ID, HDR_LEN_H, HDR_LEN_L, PAYLOAD and DROP.
REQ-010 In the three header states, cmd_s_axis_tready SHALL be 1 and each accepted byte SHALL advance the state by one.
REQ-011 On leaving HDR_LEN_L, the FSM SHALL go to:
- HDR_ID if LEN==0, with no output produced;
- DROP if the ID is invalid;
- otherwise PAYLOAD.
REQ-012 The target mask SHALL be latched in HDR_ID: a one-hot mask for a single ID, all-ones for 0xFF, zero for an invalid ID.
REQ-013 In PAYLOAD and DROP, a 16-bit remaining counter SHALL be loaded with LEN and decremented on every accepted byte; the FSM SHALL return to HDR_ID when a byte is accepted with remaining==1.
REQ-014 In DROP, cmd_s_axis_tready SHALL be 1, bytes SHALL be discarded, and stat_drop_count SHALL increment once on entry to DROP, saturating at 0xFFFF.
REQ-015 The output stage SHALL be a one-byte register: data_q, tlast_q, and pending_q[LAYER_COUNT-1:0].
- layers_mosi_m_axis_tvalid SHALL equal pending_q.
- Every lane of tlast SHALL equal tlast_q.
REQ-016 Each cycle, pending_q bit i SHALL clear when tvalid[i] and tready[i] are both high.
REQ-017 In PAYLOAD, cmd_s_axis_tready SHALL equal (pending_q & ~layers_mosi_m_axis_tready)==0, i.e. a new byte may load in the same cycle as the last outstanding lane handshakes.
REQ-018 When a PAYLOAD byte is accepted, the block SHALL set pending_q to the target mask, data_q to the byte, and tlast_q to (remaining==1). Latency from input acceptance to output tvalid SHALL be 1 cycle.
REQ-019 In broadcast, the byte SHALL be held until every layer has handshaked. Each layer SHALL receive each byte exactly once, and the layers MAY accept in different cycles.
REQ-020 tvalid SHALL NOT depend combinationally on tready; a lane, once asserted, SHALL hold its data and tlast until its handshake.
REQ-021 The next header byte SHALL be accepted while the final payload byte is still pending. The new target mask SHALL NOT alter the pending_q of the byte in flight.
REQ-022 cmd_s_axis_tready SHALL be a function of the state, pending_q and the m_tready inputs only, never of cmd_s_axis_tvalid.

Reset
REQ-023 While clk_core_resn=0 at a clk_core edge, the block SHALL:
- set state to HDR_ID;
- clear pending_q, tlast_q, data_q, the remaining counter, the latched mask and stat_drop_count;
- drive cmd_s_axis_tready=0 during the reset cycle.
REQ-024 A reset asserted mid-command SHALL abandon the command without emitting tlast; the first byte after reset release SHALL be treated as byte0.

Structure
REQ-025 A shared package layers_pkg SHALL hold the FSM state enum and the constants LAYERS_BROADCAST_ID=8'hFF and LAYERS_LEN_W=16.
REQ-026 The block SHALL contain one sub-module, layers_mosi_bcast_slice: the one-byte, multi-lane register stage with the per-lane pending mask.

Verification
REQ-027 The bench SHALL cover a single layer: command 02 00 03 AA BB CC with all readies 1 -> layer 2 sees AA, BB, CC on consecutive cycles, tlast only on CC; other lanes' tvalid stays 0.
REQ-028 The bench SHALL cover broadcast with skew: command FF 00 02 11 22, with layer 0 tready low for 3 cycles -> every layer receives 11 then 22 exactly once; cmd tready stays 0 until layer 0 accepts.
REQ-029 The bench SHALL cover an invalid ID: command 09 00 04 plus 4 bytes with LAYER_COUNT=5 -> no tvalid on any lane, stat_drop_count=1, and the next command routes correctly.
REQ-030 The bench SHALL cover zero length: command 01 00 00 followed by 01 00 01 5A -> only 5A is emitted on layer 1, with tlast.
REQ-031 The bench SHALL cover reset mid-payload: reset after 2 of 10 bytes of command 00 00 0A -> all tvalid are 0 the next cycle; the post-reset command 03 00 01 77 delivers 77 to layer 3.
REQ-032 The bench SHALL cover saturation: 65537 invalid commands -> stat_drop_count holds at 0xFFFF.
